// File: rtl/aes_chk_pkg.sv
// Shared definitions for the AES result checker: FSM encoding, fail codes and
// the FIPS-197 AES-128 reference vector.
package aes_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_ENC = 3'd1,
        ST_WAIT_DEC = 3'd2,
        ST_PASS     = 3'd3,
        ST_FAIL     = 3'd4
    } chk_state_t;

    localparam logic [1:0] FAIL_NONE    = 2'd0;
    localparam logic [1:0] FAIL_CIPHER  = 2'd1;
    localparam logic [1:0] FAIL_PLAIN   = 2'd2;
    localparam logic [1:0] FAIL_TIMEOUT = 2'd3;

    // FIPS-197 appendix C.1 AES-128 example
    localparam logic [127:0] AES_KEY    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] AES_PLAIN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] AES_CIPHER = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

endpackage

// File: rtl/aes_cs_edge.sv
// Chip-select edge detector for one SPI-style link: registers cs and flags the
// cycle a frame starts (0->1) and the cycle it ends (1->0).
module aes_cs_edge (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    output logic frame_start,
    output logic frame_end
);

    logic cs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q <= 1'b0;
        end else begin
            cs_q <= cs;
        end
    end

    assign frame_start = ~cs_q & cs;
    assign frame_end   = cs_q & ~cs;

endmodule

// File: rtl/aes_result_checker.sv
// Checks an AES encrypt frame followed by a round-trip decrypt frame against
// known vectors. Define AES_CHK_TIMEOUT_EN to bound each wait state by TIMEOUT cycles.
module aes_result_checker
    import aes_chk_pkg::*;
#(
    parameter int               WIDTH      = 128,
    parameter logic [WIDTH-1:0] EXP_CIPHER = AES_CIPHER,
    parameter logic [WIDTH-1:0] EXP_PLAIN  = AES_PLAIN,
    parameter int               TIMEOUT    = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs_enc,
    input  logic [WIDTH-1:0] enc_data,
    input  logic             cs_dec,
    input  logic [WIDTH-1:0] dec_data,
    output logic             led1,
    output logic             led2,
    output logic             led3,
    output logic             done,
    output logic [1:0]       fail_code
);

    chk_state_t state;
    chk_state_t next_state;
    logic [1:0] next_code;
    logic       led1_d;
    logic       led2_d;
    logic       led3_d;
    logic       done_d;
    logic       enc_start;
    logic       enc_end;
    logic       dec_start;
    logic       dec_end;
    logic       dec_armed;
    logic       timeout_hit;

    aes_cs_edge u_enc_edge (
        .clk         (clk),
        .rst         (rst),
        .cs          (cs_enc),
        .frame_start (enc_start),
        .frame_end   (enc_end)
    );

    aes_cs_edge u_dec_edge (
        .clk         (clk),
        .rst         (rst),
        .cs          (cs_dec),
        .frame_start (dec_start),
        .frame_end   (dec_end)
    );

`ifdef AES_CHK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    logic [CNT_W-1:0] wait_cnt;

    // Cleared on every state change so each wait state gets a fresh budget.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (next_state != state) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT_ENC || state == ST_WAIT_DEC) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // A dec frame counts only if its start was seen while already in WAIT_DEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_armed <= 1'b0;
        end else if (state != ST_WAIT_DEC && next_state == ST_WAIT_DEC) begin
            dec_armed <= 1'b0;
        end else if (state == ST_WAIT_DEC && dec_start) begin
            dec_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            led1      <= 1'b0;
            led2      <= 1'b0;
            led3      <= 1'b0;
            done      <= 1'b0;
            fail_code <= FAIL_NONE;
        end else begin
            state     <= next_state;
            led1      <= led1_d;
            led2      <= led2_d;
            led3      <= led3_d;
            done      <= done_d;
            fail_code <= next_code;
        end
    end

    // Frame events are checked before the timeout so a late event still wins.
    always_comb begin
        next_state = state;
        next_code  = fail_code;
        case (state)
            ST_IDLE: begin
                next_state = ST_WAIT_ENC;
            end
            ST_WAIT_ENC: begin
                if (enc_end) begin
                    if (enc_data == EXP_CIPHER) begin
                        next_state = ST_WAIT_DEC;
                    end else begin
                        next_state = ST_FAIL;
                        next_code  = FAIL_CIPHER;
                    end
                end else if (timeout_hit) begin
                    next_state = ST_FAIL;
                    next_code  = FAIL_TIMEOUT;
                end
            end
            ST_WAIT_DEC: begin
                if (dec_end && dec_armed) begin
                    if (dec_data == EXP_PLAIN) begin
                        next_state = ST_PASS;
                    end else begin
                        next_state = ST_FAIL;
                        next_code  = FAIL_PLAIN;
                    end
                end else if (timeout_hit) begin
                    next_state = ST_FAIL;
                    next_code  = FAIL_TIMEOUT;
                end
            end
            ST_PASS: next_state = ST_PASS;
            ST_FAIL: next_state = ST_FAIL;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        led1_d = led1 | (next_state == ST_WAIT_DEC);
        led2_d = led2 | (next_state == ST_PASS);
        led3_d = led3 | (next_state == ST_FAIL);
        done_d = (next_state == ST_PASS) || (next_state == ST_FAIL);
    end

endmodule

// File: tb/tb_aes_result_checker.sv
// Directed bench for aes_result_checker; status is compared as
// {led1, led2, led3, done, fail_code} against hand-computed constants.
module tb_aes_result_checker;

    localparam logic [127:0] CIPHER_OK  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CIPHER_BAD = 128'h69c4e0d86a7b0430d8cdb78070b4c55b;
    localparam logic [127:0] PLAIN_OK   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PLAIN_BAD  = 128'h00112233445566778899aabbccddeefe;
    localparam logic [127:0] GARBAGE    = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    logic         clk;
    logic         rst;
    logic         cs_enc;
    logic [127:0] enc_data;
    logic         cs_dec;
    logic [127:0] dec_data;
    logic         led1;
    logic         led2;
    logic         led3;
    logic         done;
    logic [1:0]   fail_code;

    int n_vec;
    int n_err;

    aes_result_checker #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_enc    (cs_enc),
        .enc_data  (enc_data),
        .cs_dec    (cs_dec),
        .dec_data  (dec_data),
        .led1      (led1),
        .led2      (led2),
        .led3      (led3),
        .done      (done),
        .fail_code (fail_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] status();
        return {led1, led2, led3, done, fail_code};
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string tag, input logic [5:0] exp);
        @(negedge clk);
        check(tag, status(), exp);
    endtask

    // Leaves the bench in the first cycle after reset release (IDLE).
    task automatic do_reset();
        step();
        rst    = 1'b1;
        cs_enc = 1'b0;
        cs_dec = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Returns in the frame-end cycle; the decision lands on the next edge.
    task automatic enc_frame(input logic [127:0] d);
        cs_enc   = 1'b1;
        enc_data = '0;
        repeat (3) step();
        cs_enc   = 1'b0;
        enc_data = d;
    endtask

    task automatic dec_frame(input logic [127:0] d);
        cs_dec   = 1'b1;
        dec_data = '0;
        repeat (3) step();
        cs_dec   = 1'b0;
        dec_data = d;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        cs_enc   = 1'b0;
        cs_dec   = 1'b0;
        enc_data = '0;
        dec_data = '0;

        // Reset state and normal pass
        do_reset();
        probe("reset", 6'b000000);
        step();
        enc_frame(CIPHER_OK);
        probe("pass_pre_enc", 6'b000000);
        step();
        probe("pass_after_enc", 6'b100000);
        step();
        dec_frame(PLAIN_OK);
        probe("pass_pre_dec", 6'b100000);
        step();
        probe("pass_after_dec", 6'b110100);
        repeat (3) step();
        probe("pass_sticky", 6'b110100);

        // Cipher mismatch, then later frames ignored
        do_reset();
        step();
        enc_frame(CIPHER_BAD);
        probe("bad_cipher_pre", 6'b000000);
        step();
        probe("bad_cipher", 6'b001101);
        step();
        enc_frame(CIPHER_OK);
        step();
        dec_frame(PLAIN_OK);
        step();
        probe("bad_cipher_terminal", 6'b001101);

        // Dec frame already open on entry to WAIT_DEC is ignored
        do_reset();
        step();
        cs_dec = 1'b1;
        enc_frame(CIPHER_OK);
        step();
        probe("open_dec_entry", 6'b100000);
        cs_dec   = 1'b0;
        dec_data = GARBAGE;
        step();
        probe("open_dec_ignored", 6'b100000);
        dec_frame(PLAIN_OK);
        step();
        probe("open_dec_then_pass", 6'b110100);

        // Dec end coincident with enc end is ignored; then plaintext mismatch
        do_reset();
        step();
        cs_enc = 1'b1;
        cs_dec = 1'b1;
        repeat (3) step();
        cs_enc   = 1'b0;
        enc_data = CIPHER_OK;
        cs_dec   = 1'b0;
        dec_data = PLAIN_OK;
        step();
        probe("same_cycle_dec_ignored", 6'b100000);
        step();
        dec_frame(PLAIN_BAD);
        step();
        probe("bad_plain", 6'b101110);

        // Reset mid-WAIT_DEC, then a clean pass
        do_reset();
        step();
        enc_frame(CIPHER_OK);
        step();
        probe("mid_rst_led1", 6'b100000);
        step();
        cs_dec = 1'b1;
        step();
        rst    = 1'b1;
        cs_dec = 1'b0;
        step();
        rst = 1'b0;
        probe("mid_rst_cleared", 6'b000000);
        step();
        enc_frame(CIPHER_OK);
        step();
        probe("after_rst_enc", 6'b100000);
        step();
        dec_frame(PLAIN_OK);
        step();
        probe("after_rst_pass", 6'b110100);

        // No enc frame at all
        do_reset();
`ifdef AES_CHK_TIMEOUT_EN
        repeat (16) @(posedge clk);
        probe("timeout_pre", 6'b000000);
        @(posedge clk);
        probe("timeout_fail", 6'b001111);
`else
        repeat (10000) @(posedge clk);
        probe("no_timeout", 6'b000000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
